// File: rtl/ascii_conv_arbiter.sv
// ============================================================================
// Module   : ascii_conv_arbiter
// Brief    : Round-robin sharing of one binary-to-ASCII converter among N
//            requesters, with converter start/done sequencing and timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ascii_conv_arbiter #(
  parameter int N       = 4,
  parameter int IDXW    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic [N-1:0]      req_valid,
  input  logic [8*N-1:0]    req_bin,
  output logic [N-1:0]      req_ready,
  output logic [N-1:0]      rsp_valid,
  output logic [31:0]       rsp_ascii,
  output logic              rsp_err,
  output logic              conv_start,
  output logic [7:0]        conv_bin,
  input  logic [31:0]       conv_ascii,
  input  logic              conv_done,
  input  logic              conv_busy,
  output logic              arb_busy,
  output logic [IDXW-1:0]   arb_owner
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_ISSUE   = 2'd1;
  localparam logic [1:0]  S_WAIT    = 2'd2;
  localparam logic [1:0]  S_DELIVER = 2'd3;

  localparam logic [15:0]     c_TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [31:0]     c_ERR_WORD = 32'h3F3F3F3F;
  localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(N - 1);

  logic [1:0]      r_state;
  logic [1:0]      w_nextState;
  logic [IDXW-1:0] r_ptr;
  logic [IDXW-1:0] r_owner;
  logic [15:0]     r_cnt;
  logic [7:0]      r_convBin;
  logic [N-1:0]    r_reqReady;
  logic [N-1:0]    r_rspValid;
  logic [31:0]     r_rspAscii;
  logic            r_rspErr;

  logic [IDXW-1:0] w_pick;
  logic            w_anyReq;
  logic            w_convStart;
  logic            w_arbBusy;
  logic            w_timeout;
  logic [N-1:0]    w_ownerOneHot;

  // Descending scan so the requester closest above the pointer wins.
  always_comb begin
    logic [IDXW:0] idx;
    idx      = '0;
    w_pick   = '0;
    w_anyReq = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, r_ptr} + (IDXW+1)'(k);
      if (idx >= (IDXW+1)'(N)) begin
        idx = idx - (IDXW+1)'(N);
      end
      if (req_valid[idx[IDXW-1:0]]) begin
        w_pick   = idx[IDXW-1:0];
        w_anyReq = 1'b1;
      end
    end
  end

  assign w_timeout     = (r_cnt == c_TO_LAST);
  assign w_ownerOneHot = N'(1) << r_owner;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:    if (w_anyReq) w_nextState = S_ISSUE;
      S_ISSUE:   if (w_convStart) w_nextState = S_WAIT;
      S_WAIT:    if (conv_done || w_timeout) w_nextState = S_DELIVER;
      S_DELIVER: w_nextState = S_IDLE;
      default:   w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    w_convStart = (r_state == S_ISSUE) && !conv_busy;
    w_arbBusy   = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_ptr      <= '0;
      r_owner    <= '0;
      r_cnt      <= '0;
      r_convBin  <= '0;
      r_reqReady <= '0;
      r_rspValid <= '0;
      r_rspAscii <= '0;
      r_rspErr   <= 1'b0;
    end else begin
      r_reqReady <= '0;
      r_rspValid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_anyReq) begin
            r_owner    <= w_pick;
            r_convBin  <= req_bin[{w_pick, 3'b000} +: 8];
            r_reqReady <= N'(1) << w_pick;
          end
        end
        S_ISSUE: begin
          if (w_convStart) begin
            r_cnt <= '0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 16'd1;
          // A done landing on the last count still returns real data.
          if (conv_done) begin
            r_rspAscii <= conv_ascii;
            r_rspErr   <= 1'b0;
            r_rspValid <= w_ownerOneHot;
          end else if (w_timeout) begin
            r_rspAscii <= c_ERR_WORD;
            r_rspErr   <= 1'b1;
            r_rspValid <= w_ownerOneHot;
          end
        end
        S_DELIVER: begin
          r_ptr <= (r_owner == c_LAST_IDX) ? '0 : r_owner + IDXW'(1);
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = r_reqReady;
  assign rsp_valid  = r_rspValid;
  assign rsp_ascii  = r_rspAscii;
  assign rsp_err    = r_rspErr;
  assign conv_start = w_convStart;
  assign conv_bin   = r_convBin;
  assign arb_busy   = w_arbBusy;
  assign arb_owner  = r_owner;

endmodule

`default_nettype wire
